// File: rtl/yvec_pkg.sv
// Shared types and helpers for the yblock stimulus/compare engine.
package yvec_pkg;

  localparam int unsigned STIM_W   = 52;
  localparam int unsigned RESP_W   = 48;
  localparam int unsigned DEPTH    = 64;
  localparam int unsigned SETTLE_W = 8;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned VCNT_W   = IDX_W + 1;
  localparam int unsigned SCNT_W   = SETTLE_W + 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_COMPARE,
    ST_DONE
  } state_e;

  typedef struct packed {
    logic [STIM_W-1:0] stim;
    logic [RESP_W-1:0] exp;
    logic [RESP_W-1:0] mask;
  } vec_t;

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/yvec_sync.sv
// Two-flop synchronizer for the asynchronous yblock response bus.
module yvec_sync #(
  parameter int unsigned W = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/yblock_vector_engine.sv
// Buffered stimulus/compare sequencer: applies stored vectors to the yblock,
// waits a settle time, and checks the masked synchronized response.
module yblock_vector_engine
  import yvec_pkg::*;
(
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                ld_valid_i,
  output logic                ld_ready_o,
  input  logic [STIM_W-1:0]   ld_stim_i,
  input  logic [RESP_W-1:0]   ld_exp_i,
  input  logic [RESP_W-1:0]   ld_mask_i,
  input  logic                clear_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [SETTLE_W-1:0] settle_i,
  output logic [STIM_W-1:0]   dut_stim_o,
  input  logic [RESP_W-1:0]   dut_resp_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [CNT_W-1:0]    err_count_o,
  output logic [IDX_W-1:0]    fail_idx_o,
  output logic [VCNT_W-1:0]   vec_count_o
);

  state_e              state_q;
  vec_t                mem_q [DEPTH];
  logic [VCNT_W-1:0]   vcount_q;
  logic [IDX_W-1:0]    idx_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [SCNT_W-1:0]   scnt_q;
  logic [STIM_W-1:0]   stim_q;
  logic                busy_q;
  logic                done_q;
  logic                pass_q;
  logic                ready_q;
  logic [CNT_W-1:0]    err_q;
  logic [IDX_W-1:0]    fail_q;

  logic [RESP_W-1:0]   resp_sync_c;
  vec_t                rd_c;
  logic                mismatch_c;
  logic                full_c;
  logic                last_c;
  logic                ld_fire_c;

  yvec_sync #(.W(RESP_W)) u_sync (
    .clk_i  (wb_clk_i),
    .rst_ni (wb_rst_ni),
    .d_i    (dut_resp_i),
    .q_o    (resp_sync_c)
  );

  assign rd_c       = mem_q[idx_q];
  assign mismatch_c = |((resp_sync_c ^ rd_c.exp) & rd_c.mask);
  assign full_c     = (vcount_q == VCNT_W'(DEPTH));
  assign last_c     = ((VCNT_W'(idx_q) + VCNT_W'(1)) == vcount_q);
  assign ld_fire_c  = wb_rst_ni && ld_valid_i && ready_q && (state_q == ST_IDLE) && !clear_i;

  // Vector storage; a reset only zeroes the count, so contents need no reset.
  always_ff @(posedge wb_clk_i) begin
    if (ld_fire_c) begin
      mem_q[vcount_q[IDX_W-1:0]] <= {ld_stim_i, ld_exp_i, ld_mask_i};
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_ni) begin
      state_q  <= ST_IDLE;
      vcount_q <= '0;
      idx_q    <= '0;
      settle_q <= SETTLE_W'(1);
      scnt_q   <= '0;
      stim_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      ready_q  <= 1'b0;
      err_q    <= '0;
      fail_q   <= '0;
    end else begin
      done_q <= 1'b0;
      // busy_q tracks APPLY/SETTLE/COMPARE exactly, so it gates abort.
      if (busy_q && abort_i) begin
        state_q <= ST_IDLE;
        stim_q  <= '0;
        busy_q  <= 1'b0;
        pass_q  <= 1'b0;
        ready_q <= !full_c;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (clear_i) begin
              vcount_q <= '0;
              ready_q  <= 1'b1;
            end else begin
              if (ld_fire_c) begin
                vcount_q <= vcount_q + VCNT_W'(1);
              end
              if (start_i) begin
                settle_q <= (settle_i == '0) ? SETTLE_W'(1) : settle_i;
                err_q    <= '0;
                fail_q   <= '0;
                pass_q   <= 1'b0;
                idx_q    <= '0;
                ready_q  <= 1'b0;
                if ((vcount_q == '0) && !ld_fire_c) begin
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
                  pass_q  <= 1'b1;
                end else begin
                  state_q <= ST_APPLY;
                  busy_q  <= 1'b1;
                end
              end else begin
                ready_q <= ld_fire_c ? (vcount_q != VCNT_W'(DEPTH - 1)) : !full_c;
              end
            end
          end
          ST_APPLY: begin
            stim_q  <= rd_c.stim;
            scnt_q  <= SCNT_W'(settle_q) + SCNT_W'(1);
            state_q <= ST_SETTLE;
          end
          ST_SETTLE: begin
            if (scnt_q == '0) begin
              state_q <= ST_COMPARE;
            end else begin
              scnt_q <= scnt_q - SCNT_W'(1);
            end
          end
          ST_COMPARE: begin
            if (mismatch_c) begin
              err_q <= sat_inc(err_q);
              if (err_q == '0) begin
                fail_q <= idx_q;
              end
            end
            if (last_c) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              pass_q  <= (err_q == '0) && !mismatch_c;
              stim_q  <= '0;
              busy_q  <= 1'b0;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_APPLY;
            end
          end
          ST_DONE: begin
            state_q <= ST_IDLE;
            ready_q <= !full_c;
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign ld_ready_o  = ready_q;
  assign dut_stim_o  = stim_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign err_count_o = err_q;
  assign fail_idx_o  = fail_q;
  assign vec_count_o = vcount_q;

endmodule

// File: doc/yblock_vector_engine.md
Name: yblock_vector_engine

Overview:
On-chip stimulus/compare engine for a yblock array. It replaces host-driven logic-analyzer vectors with a buffered, self-checking sequencer. Vectors are preloaded into an internal memory, applied to the asynchronous yblock, held for a programmable settle time, and the masked response is compared against an expected value. Error count and first-failure index are reported. It sits between the Caravel user-project glue and the yblock instance.

Parameters:
STIM_W, 52, width of one stimulus word driven to the yblock (reset, config strobe, hblock/vblock inputs)
RESP_W, 48, width of the yblock response observed
DEPTH, 64, vector memory entries; power of two, at least 2
SETTLE_W, 8, width of the settle-cycle count
CNT_W, 16, width of the error counter

Ports:
wb_clk_i  in  1  sole clock
wb_rst_ni  in  1  reset, synchronous, active-low
ld_valid_i  in  1  vector load request
ld_ready_o  out  1  load accepted this cycle when ld_valid_i & ld_ready_o
ld_stim_i  in  STIM_W  stimulus word to store
ld_exp_i  in  RESP_W  expected response
ld_mask_i  in  RESP_W  compare mask; 1 = bit checked
clear_i  in  1  empty the vector memory (IDLE only)
start_i  in  1  begin a run (IDLE only)
abort_i  in  1  stop a run immediately
settle_i  in  SETTLE_W  settle cycles per vector; sampled at start
dut_stim_o  out  STIM_W  registered stimulus to the yblock
dut_resp_i  in  RESP_W  asynchronous yblock response
busy_o  out  1  run in progress
done_o  out  1  one-cycle pulse at run completion
pass_o  out  1  last completed run had zero errors
err_count_o  out  CNT_W  mismatching vectors in the current or last run; saturates at all-ones
fail_idx_o  out  $clog2(DEPTH)  index of the first failing vector
vec_count_o  out  $clog2(DEPTH)+1  vectors stored

Behaviour:
- Reset (wb_rst_ni=0 at a clock edge): state IDLE; dut_stim_o=0; busy_o=0; done_o=0; pass_o=0; err_count_o=0; fail_idx_o=0; vec_count_o=0; ld_ready_o=0 during reset.
- Reset mid-run aborts the run and empties the memory. No partial result is kept.
- States: IDLE, APPLY, SETTLE, COMPARE, DONE.
- Load:
  - ld_ready_o = (state==IDLE) & (vec_count_o<DEPTH).
  - An accepted load writes {stim,exp,mask} at index vec_count_o, then increments the count.
  - When full, ld_ready_o=0 and the memory is unchanged.
- clear_i in IDLE sets vec_count_o=0. clear_i has priority over a same-cycle load and over start_i. clear_i is ignored outside IDLE.
- start_i in IDLE:
  - Latches settle_eff = max(settle_i,1).
  - Clears err_count_o, fail_idx_o and pass_o.
  - Sets idx=0.
  - If vec_count_o==0, goes directly to DONE (pass_o=1). Otherwise goes to APPLY.
- APPLY (1 cycle): dut_stim_o <= mem[idx].stim.
- SETTLE (settle_eff+2 cycles):
  - dut_stim_o is held.
  - dut_resp_i passes through a 2-flop synchronizer; the +2 cycles cover it.
- COMPARE (1 cycle):
  - mismatch = |((resp_sync ^ exp) & mask).
  - On mismatch: err_count_o increments, saturating.
  - On the first mismatch of the run: fail_idx_o=idx.
  - An all-zero mask never fails.
  - If idx==vec_count_o-1, go to DONE. Otherwise idx++ and go to APPLY.
- Per-vector period: settle_eff+4 cycles.
- DONE (1 cycle):
  - done_o=1 and pass_o=(err_count_o==0).
  - dut_stim_o returns to 0, so the yblock sees the default/idle value.
  - Then go to IDLE.
- busy_o=1 in APPLY, SETTLE and COMPARE.
- abort_i while busy:
  - Next state IDLE and dut_stim_o=0.
  - No done_o pulse; pass_o=0.
  - err_count_o and fail_idx_o keep their partial values.
  - The memory is retained.
- start_i while busy is ignored. abort_i in IDLE is ignored. If abort_i and the final COMPARE coincide, abort wins.
- The memory persists across runs, so the same vectors can be rerun.

Decomposition:
- Package yvec_pkg:
  - state enum.
  - Vector record {stim, exp, mask} as a packed struct built from STIM_W/RESP_W.
  - Saturating-increment function.
- One sub-module: yvec_sync, a parameterised-width 2-flop synchronizer for dut_resp_i.
- The memory is an inferred register array in the top module.

Test Plan:
- Reset/idle check. Assert wb_rst_ni=0 for 3 cycles, then release. Required: dut_stim_o=0, vec_count_o=0, ld_ready_o=1.
- Single pass run. Load 1 vector with stim=52'h1_0000_0000_0001, exp=48'h0000_0000_0001, mask=all-ones. Loop dut_resp_i to dut_stim_o[47:0]. Set settle_i=3 and pulse start_i. Required: done_o exactly 7 cycles after APPLY entry, pass_o=1, err_count_o=0.
- Mismatch and masking. Load 4 vectors; vector 2 has exp differing in bit 5. Run with mask bit 5=1: err_count_o=1, fail_idx_o=2, pass_o=0. Rerun with mask bit 5=0: pass_o=1.
- Full and clear. Load 64 vectors: ld_ready_o drops, and a 65th load is refused with vec_count_o=64. clear_i gives vec_count_o=0. start_i then gives done_o on the next cycle with pass_o=1.
- Abort mid-run. Load 8 vectors and abort during vector 3 SETTLE. Required: busy_o=0 next cycle, no done_o, dut_stim_o=0. A restart completes all 8 vectors.
- Settle edge cases. settle_i=0 gives the same timing as settle_i=1 (5-cycle period). settle_i=255 gives a 259-cycle period. A settle_i change mid-run has no effect.
